// File: rtl/eth_pkg.sv
// Shared Ethernet lab-frame definitions: frame layout constants, CRC-32
// parameters, the byte-wise CRC-32 step used by both rx and tx, and the
// receive state enum.
package eth_pkg;

  // Accepted destination MAC; byte k on the wire is MAC[8k+7:8k].
  localparam logic [47:0] MAC        = 48'h88_dab8_bf08;
  localparam logic [7:0]  SRC_BYTE   = 8'h66;
  localparam logic [7:0]  ETYPE_BYTE = 8'h19;

  localparam logic [7:0]  PRE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE   = 8'hd5;

  // Frame layout after the SFD. PAYLOAD must be a power of two.
  localparam int HDR_LEN   = 16;
  localparam int PAYLOAD   = 1024;
  localparam int FCS_LEN   = 4;
  localparam int FRAME_LEN = HDR_LEN + PAYLOAD + FCS_LEN;

  // Reflected CRC-32 (IEEE 802.3).
  localparam logic [31:0] CRC_POLY    = 32'hedb88320;
  localparam logic [31:0] CRC_INIT    = 32'hffffffff;
  localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

  typedef enum logic [2:0] {
    ST_DROP,
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_PAY,
    ST_FCS
  } rx_state_t;

  // One byte of reflected CRC-32, LSB of the data byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Expected header byte at position k (0..13) after the SFD.
  function automatic logic [7:0] hdr_byte(input logic [3:0] k);
    logic [7:0] r;
    case (k)
      4'd0:          r = MAC[7:0];
      4'd1:          r = MAC[15:8];
      4'd2:          r = MAC[23:16];
      4'd3:          r = MAC[31:24];
      4'd4:          r = MAC[39:32];
      4'd5:          r = MAC[47:40];
      4'd12, 4'd13:  r = ETYPE_BYTE;
      default:       r = SRC_BYTE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rgmii_ddr_in.sv
// RGMII DDR receive capture: low nibble and RX_CTL on the rising edge, high
// nibble and RX_CTL on the falling edge, re-assembled into one byte with
// dv/er on the following rising edge.
module rgmii_ddr_in (
  input  logic       clk125,
  input  logic       rxctl,
  input  logic [3:0] rxd,
  output logic [7:0] b,
  output logic       dv,
  output logic       er
);

  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic       ctl_rise;
  logic       ctl_fall;

  // The capture registers are intentionally not reset: a reset inside a frame
  // must keep seeing that frame's DV so the parser stays in DROP until the gap.

  // Rising-edge half: low nibble and DV.
  always_ff @(posedge clk125) begin
    lo_q     <= rxd;
    ctl_rise <= rxctl;
  end

  // Falling-edge half: high nibble and DV^ER.
  always_ff @(negedge clk125) begin
    hi_q     <= rxd;
    ctl_fall <= rxctl;
  end

  // Re-time both halves into one byte cycle on the rising edge.
  always_ff @(posedge clk125) begin
    b  <= {hi_q, lo_q};
    dv <= ctl_rise;
    er <= ctl_rise ^ ctl_fall;
  end

endmodule

// File: rtl/rx.sv
// RGMII receiver for the lab frame format. Parses preamble/SFD, checks the
// header, writes the 1024-byte payload into the inactive bank of a 2-bank
// buffer and, on a good frame, toggles idx and publishes seq.
// Optional build macro RX_STATS_EN adds good/crc-error/drop counters.
module rx
  import eth_pkg::*;
(
  input  logic        clk125,
  input  logic        rst,
  input  logic        rxctl,
  input  logic [3:0]  rxd,
  output logic        we,
  output logic [10:0] wad,
  output logic [7:0]  wdata,
  output logic        idx,
  output logic [15:0] seq
`ifdef RX_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] drop_cnt
`endif
);

  // we is a single-cycle write strobe with no back-pressure: when we is high,
  // wad/wdata are valid for that cycle and the buffer must take them.

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HDR_CMP   = 11'd14;
  localparam logic [CNT_W-1:0] SEQ_LO    = 11'd14;
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(HDR_LEN + PAYLOAD - 1);
  localparam logic [CNT_W-1:0] LEN_GOOD  = CNT_W'(FRAME_LEN);

  logic [7:0] b;
  logic       dv;
  logic       er;

  rgmii_ddr_in u_ddr (
    .clk125 (clk125),
    .rxctl  (rxctl),
    .rxd    (rxd),
    .b      (b),
    .dv     (dv),
    .er     (er)
  );

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      crc, crc_n;
  logic             hdr_bad, hdr_bad_n;
  logic             er_seen, er_seen_n;
  logic [15:0]      seq_tmp, seq_tmp_n;
  logic             we_n;
  logic [10:0]      wad_n;
  logic [7:0]       wdata_n;
  logic             idx_n;
  logic [15:0]      seq_n;

  logic in_frame;
  logic eof;
  logic len_ok;
  logic crc_ok;
  logic frame_good;

  // End of frame is the first dv=0 byte cycle once past the SFD.
  assign in_frame   = (state == ST_HDR) || (state == ST_PAY) || (state == ST_FCS);
  assign eof        = in_frame && !dv;
  assign len_ok     = (cnt == LEN_GOOD);
  assign crc_ok     = (crc == CRC_RESIDUE);
  assign frame_good = eof && len_ok && crc_ok && !hdr_bad && !er_seen;

  // State and datapath registers.
  always_ff @(posedge clk125) begin
    if (rst) begin
      state   <= ST_DROP;
      cnt     <= '0;
      crc     <= CRC_INIT;
      hdr_bad <= 1'b0;
      er_seen <= 1'b0;
      seq_tmp <= '0;
      we      <= 1'b0;
      wad     <= '0;
      wdata   <= '0;
      idx     <= 1'b0;
      seq     <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      crc     <= crc_n;
      hdr_bad <= hdr_bad_n;
      er_seen <= er_seen_n;
      seq_tmp <= seq_tmp_n;
      we      <= we_n;
      wad     <= wad_n;
      wdata   <= wdata_n;
      idx     <= idx_n;
      seq     <= seq_n;
    end
  end

  // Next-state and next-output logic, one step per received byte cycle.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    crc_n     = crc;
    hdr_bad_n = hdr_bad;
    er_seen_n = er_seen;
    seq_tmp_n = seq_tmp;
    we_n      = 1'b0;
    wad_n     = wad;
    wdata_n   = wdata;
    idx_n     = idx;
    seq_n     = seq;

    case (state)
      ST_DROP: begin
        if (!dv) state_n = ST_IDLE;
      end

      ST_IDLE: begin
        if (dv) state_n = (b == PRE_BYTE) ? ST_PRE : ST_DROP;
      end

      // IDLE already consumed one 0x55, so an SFD here always follows preamble.
      ST_PRE: begin
        if (!dv) begin
          state_n = ST_IDLE;
        end else if (b == SFD_BYTE) begin
          state_n   = ST_HDR;
          cnt_n     = '0;
          crc_n     = CRC_INIT;
          hdr_bad_n = 1'b0;
          er_seen_n = 1'b0;
        end else if (b != PRE_BYTE) begin
          state_n = ST_DROP;
        end
      end

      ST_HDR, ST_PAY, ST_FCS: begin
        if (!dv) begin
          state_n = ST_IDLE;
          if (frame_good) begin
            idx_n = ~idx;
            seq_n = seq_tmp;
          end
        end else begin
          crc_n = crc32_byte(crc, b);
          // Saturating count keeps an overlong frame from wrapping back to 1044.
          if (cnt != CNT_MAX) cnt_n = cnt + 11'd1;
          if (er) er_seen_n = 1'b1;

          if (state == ST_HDR) begin
            if (cnt < HDR_CMP) begin
              if (b != hdr_byte(cnt[3:0])) hdr_bad_n = 1'b1;
            end else if (cnt == SEQ_LO) begin
              seq_tmp_n[7:0] = b;
            end else begin
              seq_tmp_n[15:8] = b;
            end
            if (cnt == HDR_LAST) state_n = ST_PAY;
          end else if (state == ST_PAY) begin
            we_n    = 1'b1;
            wdata_n = b;
            wad_n   = {~idx, cnt[9:0] - 10'(HDR_LEN)};
            if (cnt == PAY_LAST) state_n = ST_FCS;
          end
          // ST_FCS: only the CRC and length keep running.
        end
      end

      default: state_n = ST_DROP;
    endcase
  end

`ifdef RX_STATS_EN
  logic eof_crc_err;
  logic eof_drop;

  // A right-length frame failing only the residue is a CRC error; anything
  // else bad is a drop.
  assign eof_crc_err = eof && len_ok && !crc_ok;
  assign eof_drop    = eof && !frame_good && !eof_crc_err;

  // Saturating frame statistics.
  always_ff @(posedge clk125) begin
    if (rst) begin
      good_cnt    <= '0;
      crc_err_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (frame_good && (good_cnt != 16'hffff))     good_cnt    <= good_cnt + 16'd1;
      if (eof_crc_err && (crc_err_cnt != 16'hffff)) crc_err_cnt <= crc_err_cnt + 16'd1;
      if (eof_drop && (drop_cnt != 16'hffff))       drop_cnt    <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/rx.md
Name: rx

Overview:
- RGMII receive counterpart of the lab frame transmitter.
- Captures DDR nibbles on clk125 and assembles bytes. Parses the fixed frame: preamble, SFD, dst MAC, src MAC, ethertype 0x1919, 2-byte sequence, 1024-byte payload, FCS.
- Writes the payload into the inactive bank of a 2x1024-byte buffer.
- On a good frame, flips the bank by toggling idx and publishes seq. Downstream logic detects the toggle exactly as the transmitter's idx input does.

Parameters:
- MAC, 48'h88_dab8_bf08: accepted destination MAC; byte k on the wire is MAC[8k+7:8k], so the wire order is 08 bf b8 da 88 00.
- SRC_BYTE, 8'h66: expected value of all 6 source-MAC bytes.
- ETYPE_BYTE, 8'h19: expected value of both ethertype bytes.
- PAYLOAD, 1024: payload bytes per frame; must be a power of two.

Ports:
- clk125  in  1  125 MHz RGMII receive clock.
- rst  in  1  synchronous active-high reset, sampled on posedge clk125.
- rxctl  in  1  RGMII RX_CTL: DV on the rising edge, DV^ER on the falling edge.
- rxd  in  4  RGMII data: byte[3:0] on the rising edge, byte[7:4] on the falling edge.
- we  out  1  payload write strobe.
- wad  out  11  write address {bank, offset[9:0]}.
- wdata  out  8  payload byte.
- idx  out  1  toggles once per accepted frame; value = bank holding the latest good payload.
- seq  out  16  sequence field of the latest good frame; first wire byte = seq[7:0].

Behaviour:
- Capture:
  - Low nibble and DV registered at posedge; high nibble and DV^ER registered at negedge.
  - Assembled byte b, dv, er = (ctl_rise ^ ctl_fall) registered at the following posedge. This is "byte cycle" T.
  - All remaining logic is posedge only.
- Reset values: we=0, wad=0, wdata=0, idx=0, seq=0, crc=32'hffffffff, cnt=0, state=DROP.
- Starting in DROP means a reset mid-frame discards the remainder of that frame.
- State machine, evaluated on each byte cycle:
  - DROP: wait for dv=0, then go to IDLE.
  - IDLE:
    - dv & b==55 -> PRE.
    - dv & other byte -> DROP.
  - PRE:
    - b==55 -> stay (count up to 7).
    - b==d5 after at least 1 byte of 55 -> HDR, with cnt=0 and crc=ffffffff.
    - Any other byte, or dv=0 -> DROP/IDLE respectively.
  - HDR, cnt 0..15:
    - Compare against MAC[cnt] (cnt 0..5), SRC_BYTE (6..11), ETYPE_BYTE (12..13); latch seq_tmp bytes at cnt 14..15.
    - Any mismatch sets a sticky bad flag; reception continues.
  - PAY, cnt 16..16+PAYLOAD-1: we=1 at T+1 with wdata=b and wad={~idx, cnt-16}.
  - FCS, 4 bytes: CRC register keeps running over them.
- CRC: reflected poly edb88320, init ffffffff, LSB first. Covers every byte after the SFD, FCS included.
- End of frame: the first byte cycle with dv=0 after HDR is entered. A frame is good iff all of:
  - total bytes after SFD == 16+PAYLOAD+4 (1044);
  - crc residue == 32'hdebb20e3;
  - no header mismatch;
  - no er seen.
- On good: at T+1 of the end cycle, idx <= ~idx and seq <= seq_tmp; both update in the same cycle.
- On bad: idx and seq hold; the inactive bank holds garbage, which is harmless.
- Overrun: more than 1044 bytes sets bad and suppresses we. Payload writes never exceed offset 1023.
- dv=0 during PRE/IDLE returns to IDLE with no output. A new preamble directly after end-of-frame (one dv=0 byte gap) must be accepted.
- we is only asserted in PAY; wad offset wraps never.

Optional Feature:
- RX_STATS_EN defined: adds outputs good_cnt, crc_err_cnt, drop_cnt (16 bits each, saturating at ffff, reset to 0).
  - good_cnt increments with each idx toggle.
  - crc_err_cnt increments on a residue mismatch with correct length.
  - drop_cnt increments on any other bad end-of-frame: length, header, er, or overrun.
- Undefined: no counters and no extra ports.

Decomposition:
- Shared package eth_pkg holds:
  - frame constants: MAC, SRC_BYTE, ETYPE_BYTE, header length 16, PAYLOAD, FCS length 4;
  - CRC poly and residue;
  - the byte-wise crc32 function, also used by tx;
  - the state enum.
- One sub-module, rgmii_ddr_in: DDR capture of rxd/rxctl to {b, dv, er} on posedge.

Test Plan:
- Good frame: seq=0x1234, payload[i]=i[7:0] -> 1024 writes, wad=0x400..0x7ff, idx 0->1, seq=0x1234.
- Two back-to-back good frames with a 1-byte gap, seq 5 and 6 -> second frame writes wad 0x000..0x3ff, idx 1->0, seq=6.
- Frame with one payload bit flipped -> writes occur but idx/seq hold; crc_err_cnt=1 under RX_STATS_EN.
- Destination MAC byte 0 = 0x09, valid FCS -> idx holds; drop_cnt=1.
- Truncated frame (dv drops after 500 payload bytes), then a good frame -> first ignored, second accepted, idx toggles once.
- rst asserted mid-payload for 1 cycle -> outputs at reset values, rest of frame ignored; next good frame accepted with idx 0->1.
